// File: rtl/rooth_uart_tx.sv
// rooth_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Firmware pushes bytes through TXDATA; the bit-timing FSM shifts them out LSB first.
module rooth_uart_tx #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BAUD_RST   = 434,
    parameter int unsigned BAUD_MIN   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        tx_pin,
    output logic        irq_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // Register decode
    logic wr_ctrl, wr_status, wr_baud, wr_txdata;
    assign wr_ctrl   = we_i && (addr_i[3:2] == 2'd0);
    assign wr_status = we_i && (addr_i[3:2] == 2'd1);
    assign wr_baud   = we_i && (addr_i[3:2] == 2'd2);
    assign wr_txdata = we_i && (addr_i[3:2] == 2'd3);

    logic unused_bits;
    assign unused_bits = ^{addr_i[7:4], addr_i[1:0], wdata_i[31:16]};

    // Control/status state
    logic        tx_en_q, irq_en_q, ovf_q;
    logic [15:0] baud_q;

    // FIFO state; pointers carry an extra wrap bit to tell full from empty
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full, push, pop, ovf_set;

    // Transmitter state
    state_e      state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d, div_q, div_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        baud_done, start_ok, busy;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign baud_done = (baud_cnt_q == div_q - 16'd1);
    assign start_ok  = tx_en_q && !fifo_empty;
    // A frame is loaded from idle, or straight out of a finished stop bit
    assign pop       = start_ok && ((state_q == StIdle) || ((state_q == StStop) && baud_done));
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push      = wr_txdata && (!fifo_full || pop);
    assign ovf_set   = wr_txdata && !push;
    assign busy      = (state_q != StIdle);

    // Control registers; a new overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            baud_q   <= 16'(BAUD_RST);
            ovf_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                tx_en_q  <= wdata_i[0];
                irq_en_q <= wdata_i[1];
            end
            if (wr_baud) begin
                baud_q <= (wdata_i[15:0] < 16'(BAUD_MIN)) ? 16'(BAUD_MIN) : wdata_i[15:0];
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end else if (wr_status && wdata_i[3]) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // FIFO pointers; reset discards any queued bytes
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO storage, no reset needed since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= wdata_i[7:0];
        end
    end

    // Transmitter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            div_q      <= 16'(BAUD_RST);
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            div_q      <= div_d;
            tx_q       <= tx_d;
        end
    end

    // Bit-timing next state: each state lasts div_q cycles, data shifts out LSB first
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        div_d      = div_q;
        tx_d       = tx_q;
        case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                tx_d       = 1'b1;
            end
            StStart: begin
                if (baud_done) begin
                    state_d    = StData;
                    baud_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = shift_q[0];
                    shift_d    = {1'b0, shift_q[7:1]};
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            StStop: begin
                if (baud_done) begin
                    state_d    = StIdle;
                    baud_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        // Loading a new frame overrides the idle/stop outcome above
        if (pop) begin
            state_d    = StStart;
            baud_cnt_d = '0;
            shift_d    = fifo_mem[rd_ptr_q[AW-1:0]];
            div_d      = baud_q;
            tx_d       = 1'b0;
        end
    end

    // Register read mux
    always_comb begin
        rdata_o = '0;
        case (addr_i[3:2])
            2'd0:    rdata_o[1:0]  = {irq_en_q, tx_en_q};
            2'd1:    rdata_o[3:0]  = {ovf_q, fifo_empty, fifo_full, busy};
            2'd2:    rdata_o[15:0] = baud_q;
            default: rdata_o       = '0;
        endcase
    end

    assign tx_pin = tx_q;
    assign irq_o  = irq_en_q && fifo_empty && (state_q == StIdle);

endmodule

// File: tb/tb_rooth_uart_tx.sv
// Testbench for rooth_uart_tx: directed steps plus randomized frames against a
// frame-level model that expands each byte into start/data/stop bit periods.
module tb_rooth_uart_tx;

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_STATUS = 8'h04;
    localparam logic [7:0] A_BAUD   = 8'h08;
    localparam logic [7:0] A_TXDATA = 8'h0C;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_i;
    logic [7:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        tx_pin;
    logic        irq_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected frames for the wave checker: bytes and the divisor each one uses
    logic [7:0] bq[$];
    int         dq[$];

    always #5 clk = ~clk;

    rooth_uart_tx #(
        .FIFO_DEPTH(4),
        .BAUD_RST  (434),
        .BAUD_MIN  (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we_i),
        .addr_i (addr_i),
        .wdata_i(wdata_i),
        .rdata_o(rdata_o),
        .tx_pin (tx_pin),
        .irq_o  (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        @(posedge clk);
        #1;
        we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        addr_i = a;
        #1;
        d = rdata_o;
    endtask

    // Call just after the edge that makes the first frame poppable; checks every
    // cycle of the back-to-back frames in bq/dq, one comparison per frame.
    task automatic check_wave(input string tag);
        logic [9:0] frame;
        int         bad;
        @(posedge clk);
        for (int f = 0; f < bq.size(); f++) begin
            frame = {1'b1, bq[f], 1'b0};
            bad   = 0;
            for (int b = 0; b < 10; b++) begin
                for (int c = 0; c < dq[f]; c++) begin
                    @(negedge clk);
                    if (tx_pin !== frame[b]) bad++;
                end
            end
            check($sformatf("%s frame%0d byte 0x%0h bad cycles", tag, f, bq[f]), bad, 0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          bad;
        int          v;
        int          n;

        rst     = 1'b1;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: reset state
        bus_read(A_CTRL, rd);   check("rst ctrl", rd, 32'h0);
        bus_read(A_STATUS, rd); check("rst status", rd, 32'h4);
        bus_read(A_BAUD, rd);   check("rst baud", rd, 32'd434);
        bus_read(A_TXDATA, rd); check("rst txdata read", rd, 32'h0);
        check("rst tx_pin", tx_pin, 1'b1);
        check("rst irq", irq_o, 1'b0);

        // 2: single 0x55 frame at 8 clocks/bit
        bus_write(A_BAUD, 32'd8);
        bus_write(A_CTRL, 32'h1);
        bus_write(A_TXDATA, 32'h55);
        bq = {}; dq = {};
        bq.push_back(8'h55); dq.push_back(8);
        check_wave("t2");
        bus_read(A_STATUS, rd); check("t2 busy at cycle 80", rd[0], 1'b1);
        @(negedge clk);
        bus_read(A_STATUS, rd); check("t2 busy after 80", rd[0], 1'b0);

        // 3: fill FIFO with tx disabled, overflow, then four back-to-back frames
        bus_write(A_BAUD, 32'd4);
        bus_write(A_CTRL, 32'h0);
        bus_write(A_TXDATA, 32'hA1);
        bus_write(A_TXDATA, 32'hB2);
        bus_write(A_TXDATA, 32'hC3);
        bus_write(A_TXDATA, 32'hD4);
        bus_read(A_STATUS, rd); check("t3 full", rd, 32'h2);
        bus_write(A_TXDATA, 32'hE5);
        bus_read(A_STATUS, rd); check("t3 overflow", rd, 32'hA);
        bq = {}; dq = {};
        bq.push_back(8'hA1); bq.push_back(8'hB2); bq.push_back(8'hC3); bq.push_back(8'hD4);
        repeat (4) dq.push_back(4);
        bus_write(A_CTRL, 32'h1);
        check_wave("t3");
        @(negedge clk);
        bus_read(A_STATUS, rd); check("t3 drained", rd, 32'hC);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_pin !== 1'b1) bad++;
        end
        check("t3 dropped byte not sent", bad, 0);
        bus_write(A_STATUS, 32'h8);
        bus_read(A_STATUS, rd); check("t3 overflow clear", rd, 32'h4);

        // 4: clamp, and divisor change mid-frame only affects the next frame
        bus_write(A_BAUD, 32'd2);
        bus_read(A_BAUD, rd); check("t4 baud clamp", rd, 32'd4);
        bus_write(A_TXDATA, 32'h3C);
        bq = {}; dq = {};
        bq.push_back(8'h3C); bq.push_back(8'h96);
        dq.push_back(4); dq.push_back(16);
        fork
            check_wave("t4");
            begin
                repeat (3) @(posedge clk);
                bus_write(A_BAUD, 32'd16);
                bus_write(A_TXDATA, 32'h96);
            end
        join
        bus_read(A_BAUD, rd); check("t4 baud readback", rd, 32'd16);
        @(negedge clk);
        bus_read(A_STATUS, rd); check("t4 idle after", rd, 32'h4);

        // 5: interrupt low for the whole frame, high again once idle and empty
        bus_write(A_BAUD, 32'd4);
        bus_write(A_CTRL, 32'h3);
        @(negedge clk);
        check("t5 irq idle", irq_o, 1'b1);
        bus_write(A_TXDATA, 32'hA5);
        bad = 0;
        repeat (41) begin
            @(negedge clk);
            if (irq_o !== 1'b0) bad++;
        end
        check("t5 irq low during frame", bad, 0);
        @(negedge clk);
        check("t5 irq after frame", irq_o, 1'b1);

        // 6: reset in the middle of the data bits of 0x0F
        bus_write(A_TXDATA, 32'h0F);
        bus_write(A_TXDATA, 32'h33);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("t6 tx data bit4", tx_pin, 1'b0);
        bus_read(A_STATUS, rd); check("t6 busy before rst", rd, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 tx after rst", tx_pin, 1'b1);
        check("t6 irq after rst", irq_o, 1'b0);
        bus_read(A_STATUS, rd); check("t6 status after rst", rd, 32'h4);
        bus_read(A_CTRL, rd);   check("t6 ctrl after rst", rd, 32'h0);
        rst = 1'b0;
        bus_write(A_CTRL, 32'h1);
        bus_read(A_BAUD, rd); check("t6 baud after rst", rd, 32'd434);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            bus_read(A_STATUS, rd);
            if (tx_pin !== 1'b1 || rd !== 32'h4) bad++;
        end
        check("t6 no resume", bad, 0);

        // Randomized divisors (including sub-minimum values) and byte bursts
        for (int r = 0; r < 4; r++) begin
            v = int'($urandom_range(0, 12));
            bus_write(A_BAUD, 32'(v));
            if (v < 4) v = 4;
            bus_read(A_BAUD, rd); check($sformatf("rnd%0d baud", r), rd, 32'(v));
            n = int'($urandom_range(1, 4));
            bq = {}; dq = {};
            for (int i = 0; i < n; i++) begin
                bq.push_back(8'($urandom));
                dq.push_back(v);
            end
            bus_write(A_TXDATA, {24'h0, bq[0]});
            fork
                check_wave($sformatf("rnd%0d", r));
                begin
                    for (int i = 1; i < n; i++) bus_write(A_TXDATA, {24'h0, bq[i]});
                end
            join
            @(negedge clk);
            bus_read(A_STATUS, rd); check($sformatf("rnd%0d idle", r), rd, 32'h4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
